ramdes_mc: RTL and testbench

Multi-channel successor to the single-user shared RAM. It exposes an Avalon-MM slave port to the PCIe host side and N user-IP write channels with valid/ready handshakes. A round-robin arbiter serves the user channels, and host writes always win. Reads are pipelined with `readdatavalid`, and a saturating stall counter reports host/user contention. The block sits between the PCIe BAR interconnect and user logic that streams results into host-visible memory.

---
 rtl/ramdes_mc.sv | 100 ++++++++++
 tb/tb_ramdes_mc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ramdes_mc.sv
// Shared host/user RAM: Avalon-MM host port plus N round-robin user write channels (RAMDES_MC_BYTEEN_EN enables host byte lanes).
// Latency: writes visible the next edge; reads return readdata/readdatavalid one edge after the read is sampled.
// Backpressure: host writes always win; usr_ready is a combinational grant and stall_cnt counts host-blocked user cycles.
module ramdes_mc #(
   parameter int B = 32,
   parameter int W = 10,
   parameter int N = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [W-1:0]     address,
   input  logic             write_n,
   input  logic             read_n,
   input  logic [B-1:0]     writedata,
   input  logic [B/8-1:0]   byteenable,
   output logic [B-1:0]     readdata,
   output logic             readdatavalid,
   input  logic [N-1:0]     usr_valid,
   output logic [N-1:0]     usr_ready,
   input  logic [N*W-1:0]   usr_addr,
   input  logic [N*B-1:0]   usr_data,
   output logic [15:0]      stall_cnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [B-1:0]  mem [0:(1<<W)-1];
   logic [B-1:0]  rd_dat;
   logic          rd_pend;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] scan_idx;
   logic          usr_go;

   // First valid channel at or after rr_ptr, wrapping mod N; blocked while the host writes.
   always_comb begin
      usr_ready = '0;
      usr_go    = 1'b0;
      gnt_idx   = '0;
      scan_idx  = '0;
      if (write_n) begin
         for (int k = 0; k < N; k++) begin
            scan_idx = PW'((int'(rr_ptr) + k) % N);
            if (!usr_go && usr_valid[scan_idx]) begin
               usr_go             = 1'b1;
               gnt_idx            = scan_idx;
               usr_ready[scan_idx] = 1'b1;
            end
         end
      end
   end

`ifndef RAMDES_MC_BYTEEN_EN
   logic unused_be;
   assign unused_be = ^byteenable;
`endif

   // Storage has no reset; rd_dat samples the array before this edge's write lands (old data on collision).
   always_ff @(posedge clk) begin
      if (!write_n) begin
`ifdef RAMDES_MC_BYTEEN_EN
         for (int j = 0; j < B/8; j++) begin
            if (byteenable[j]) begin
               mem[address][j*8 +: 8] <= writedata[j*8 +: 8];
            end
         end
`else
         mem[address] <= writedata;
`endif
      end else if (usr_go) begin
         mem[usr_addr[gnt_idx*W +: W]] <= usr_data[gnt_idx*B +: B];
      end
      if (!read_n) begin
         rd_dat <= mem[address];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend       <= 1'b0;
         readdatavalid <= 1'b0;
         readdata      <= '0;
         rr_ptr        <= '0;
         stall_cnt     <= '0;
      end else begin
         rd_pend       <= !read_n;
         readdatavalid <= rd_pend;
         if (rd_pend) begin
            readdata <= rd_dat;
         end
         if (usr_go) begin
            rr_ptr <= PW'((int'(gnt_idx) + 1) % N);
         end
         if (!write_n && (|usr_valid) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ramdes_mc.sv
// Directed vector table plus hand sequences for stall saturation and reset during a pending read.
module tb_ramdes_mc;
   localparam int B = 32;
   localparam int W = 10;
   localparam int N = 2;

   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] CA = 32'hA0A0A0A0;
   localparam logic [31:0] CB = 32'hB1B1B1B1;
   localparam logic [31:0] CC = 32'hC0C0C0C0;
`ifdef RAMDES_MC_BYTEEN_EN
   localparam logic [31:0] BE = 32'hFF00FF00;
`else
   localparam logic [31:0] BE = 32'h00000000;
`endif

   logic            clk = 1'b0;
   logic            reset_n;
   logic [W-1:0]    address;
   logic            write_n;
   logic            read_n;
   logic [B-1:0]    writedata;
   logic [B/8-1:0]  byteenable;
   logic [B-1:0]    readdata;
   logic            readdatavalid;
   logic [N-1:0]    usr_valid;
   logic [N-1:0]    usr_ready;
   logic [N*W-1:0]  usr_addr;
   logic [N*B-1:0]  usr_data;
   logic [15:0]     stall_cnt;

   always #5 clk = ~clk;

   ramdes_mc #(.B(B), .W(W), .N(N)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
      .read_n(read_n), .writedata(writedata), .byteenable(byteenable),
      .readdata(readdata), .readdatavalid(readdatavalid), .usr_valid(usr_valid),
      .usr_ready(usr_ready), .usr_addr(usr_addr), .usr_data(usr_data),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic        wr;
      logic        rd;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [1:0]  uv;
      logic [9:0]  ua0;
      logic [31:0] ud0;
      logic [9:0]  ua1;
      logic [31:0] ud1;
      logic [1:0]  e_rdy;
      logic        e_rdv;
      logic [31:0] e_rd;
      logic [15:0] e_st;
   } vec_t;

   localparam int NV = 30;
   vec_t tv [NV];
   int n_chk = 0;
   int n_bad = 0;

   function automatic vec_t mk(input logic wr, input logic rd, input logic [9:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input logic [1:0] uv,
                               input logic [9:0] ua0, input logic [31:0] ud0,
                               input logic [9:0] ua1, input logic [31:0] ud1,
                               input logic [1:0] e_rdy, input logic e_rdv,
                               input logic [31:0] e_rd, input logic [15:0] e_st);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.be = be; v.uv = uv;
      v.ua0 = ua0; v.ud0 = ud0; v.ua1 = ua1; v.ud1 = ud1;
      v.e_rdy = e_rdy; v.e_rdv = e_rdv; v.e_rd = e_rd; v.e_st = e_st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      write_n    = ~v.wr;
      read_n     = ~v.rd;
      address    = v.addr;
      writedata  = v.wdata;
      byteenable = v.be;
      usr_valid  = v.uv;
      usr_addr   = {v.ua1, v.ua0};
      usr_data   = {v.ud1, v.ud0};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //      wr rd addr wdata         be       uv  ua0 ud0  ua1 ud1  rdy rdv rd   st
      tv[0]  = mk(1, 0, 5,  DB,           4'hF,    0, 0,  0,   0,  0,   0, 0, 0,   0);
      tv[1]  = mk(0, 1, 5,  0,            4'hF,    0, 0,  0,   0,  0,   0, 0, 0,   0);
      tv[2]  = mk(0, 0, 0,  0,            4'hF,    0, 0,  0,   0,  0,   0, 1, DB,  0);
      tv[3]  = mk(0, 0, 0,  0,            4'hF,    0, 0,  0,   0,  0,   0, 0, DB,  0);
      tv[4]  = mk(0, 0, 0,  0,            4'hF,    3, 10, CA,  11, CB,  1, 0, DB,  0);
      tv[5]  = mk(0, 0, 0,  0,            4'hF,    3, 10, CA,  11, CB,  2, 0, DB,  0);
      tv[6]  = mk(0, 0, 0,  0,            4'hF,    3, 10, CA,  11, CB,  1, 0, DB,  0);
      tv[7]  = mk(0, 0, 0,  0,            4'hF,    3, 10, CA,  11, CB,  2, 0, DB,  0);
      tv[8]  = mk(0, 1, 10, 0,            4'hF,    0, 0,  0,   0,  0,   0, 0, DB,  0);
      tv[9]  = mk(0, 1, 11, 0,            4'hF,    0, 0,  0,   0,  0,   0, 1, CA,  0);
      tv[10] = mk(0, 0, 0,  0,            4'hF,    0, 0,  0,   0,  0,   0, 1, CB,  0);
      tv[11] = mk(1, 0, 3,  32'h33333333, 4'hF,    1, 3,  CC,  0,  0,   0, 0, CB,  1);
      tv[12] = mk(0, 0, 0,  0,            4'hF,    1, 3,  CC,  0,  0,   1, 0, CB,  1);
      tv[13] = mk(0, 1, 3,  0,            4'hF,    0, 0,  0,   0,  0,   0, 0, CB,  1);
      tv[14] = mk(0, 0, 0,  0,            4'hF,    0, 0,  0,   0,  0,   0, 1, CC,  1);
      tv[15] = mk(1, 0, 7,  0,            4'hF,    0, 0,  0,   0,  0,   0, 0, CC,  1);
      tv[16] = mk(1, 1, 7,  1,            4'hF,    0, 0,  0,   0,  0,   0, 0, CC,  1);
      tv[17] = mk(0, 1, 7,  0,            4'hF,    0, 0,  0,   0,  0,   0, 1, 0,   1);
      tv[18] = mk(0, 0, 0,  0,            4'hF,    0, 0,  0,   0,  0,   0, 1, 1,   1);
      tv[19] = mk(1, 0, 20, 32'hFFFFFFFF, 4'hF,    0, 0,  0,   0,  0,   0, 0, 1,   1);
      tv[20] = mk(1, 0, 20, 0,            4'b0101, 0, 0,  0,   0,  0,   0, 0, 1,   1);
      tv[21] = mk(0, 1, 20, 0,            4'hF,    0, 0,  0,   0,  0,   0, 0, 1,   1);
      tv[22] = mk(0, 0, 0,  0,            4'hF,    0, 0,  0,   0,  0,   0, 1, BE,  1);
      tv[23] = mk(0, 0, 0,  0,            4'hF,    1, 30, 5,   31, 6,   1, 0, BE,  1);
      tv[24] = mk(0, 0, 0,  0,            4'hF,    2, 30, 5,   31, 6,   2, 0, BE,  1);
      tv[25] = mk(1, 0, 32, 9,            4'hF,    3, 30, 5,   31, 6,   0, 0, BE,  2);
      tv[26] = mk(0, 0, 0,  0,            4'hF,    3, 30, 5,   31, 6,   1, 0, BE,  2);
      tv[27] = mk(0, 1, 30, 0,            4'hF,    0, 0,  0,   0,  0,   0, 0, BE,  2);
      tv[28] = mk(0, 1, 31, 0,            4'hF,    0, 0,  0,   0,  0,   0, 1, 5,   2);
      tv[29] = mk(0, 0, 0,  0,            4'hF,    0, 0,  0,   0,  0,   0, 1, 6,   2);

      reset_n = 1'b0;
      drive(mk(0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #22;
      chk("rst_readdata", readdata, 0);
      chk("rst_rdv", {31'b0, readdatavalid}, 0);
      chk("rst_stall", {16'b0, stall_cnt}, 0);
      chk("rst_rdy", {30'b0, usr_ready}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tv[i]);
         #1;
         chk($sformatf("v%0d_rdy", i), {30'b0, usr_ready}, {30'b0, tv[i].e_rdy});
         step();
         chk($sformatf("v%0d_rdv", i), {31'b0, readdatavalid}, {31'b0, tv[i].e_rdv});
         chk($sformatf("v%0d_rd", i), readdata, tv[i].e_rd);
         chk($sformatf("v%0d_stall", i), {16'b0, stall_cnt}, {16'b0, tv[i].e_st});
      end

      // Saturation: counter sits at 2, host blocks channel 0 continuously.
      @(negedge clk);
      drive(mk(1, 0, 40, 32'h12345678, 4'hF, 1, 41, 7, 0, 0, 0, 0, 0, 0));
      #1;
      chk("sat_rdy_blocked", {30'b0, usr_ready}, 0);
      for (int i = 0; i < 65532; i++) step();
      chk("sat_fffe", {16'b0, stall_cnt}, 32'h0000FFFE);
      step();
      chk("sat_ffff", {16'b0, stall_cnt}, 32'h0000FFFF);
      for (int i = 0; i < 4000; i++) step();
      chk("sat_hold", {16'b0, stall_cnt}, 32'h0000FFFF);

      // Reset lands between the read sample and its data return.
      @(negedge clk);
      drive(mk(0, 1, 5, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      chk("mid_pending_rdv", {31'b0, readdatavalid}, 0);
      @(negedge clk);
      read_n  = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_rdv", {31'b0, readdatavalid}, 0);
      chk("mid_rst_rd", readdata, 0);
      chk("mid_rst_stall", {16'b0, stall_cnt}, 0);
      step();
      chk("mid_rst_edge_rdv", {31'b0, readdatavalid}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      chk("post_rst_rdv", {31'b0, readdatavalid}, 0);
      chk("post_rst_rd", readdata, 0);

      @(negedge clk);
      drive(mk(0, 1, 5, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      @(negedge clk);
      read_n = 1'b1;
      step();
      chk("recover_rdv", {31'b0, readdatavalid}, 1);
      chk("recover_rd", readdata, DB);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
